// File: rtl/warp_sequencer_if.sv
// warp_sequencer_if: pixel-RAM port and frame-readout port of the warp sequencer.
// The master modport is the sequencer's side. The slave modport is the RAM/readout side.
interface warp_sequencer_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 8
);
    // Single-port pixel RAM: synchronous read with 1-cycle latency
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] ram_q;

    // Readout requester: one accepted request gives one result on the next cycle
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output ram_we, ram_addr, ram_data, rd_ready, rd_valid, rd_data,
        input  ram_q, rd_req, rd_addr
    );

    modport slave (
        input  ram_we, ram_addr, ram_data, rd_ready, rd_valid, rd_data,
        output ram_q, rd_req, rd_addr
    );
endinterface

// File: rtl/warp_sequencer.sv
// warp_sequencer: copies a full source frame to the destination frame through the
// warp module. It runs one RD / WT / WR sequence per pixel in raster order. When no
// copy is running, it lends the pixel RAM to the readout requester.
// Optional feature macro: WARP_BOUNDS_CHECK_EN. It suppresses writes whose warped
// offset falls outside the frame and counts them in drop_count.
module warp_sequencer #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int ADDR_W   = 21,
    parameter int DATA_W   = 8,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 400000,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [9:0]        warp_i,
    output logic [9:0]        warp_j,
    input  logic [ADDR_W-1:0] warp_out,
    warp_sequencer_if.master  bus,
    output logic [19:0]       drop_count
);
    localparam int                NPIX     = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] NPIX_A   = ADDR_W'(NPIX);
    localparam logic [9:0]        LAST_COL = 10'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
    localparam int                WC_W     = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WT   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_woff;
    logic [9:0]        r_row;
    logic [9:0]        r_col;
    logic [DATA_W-1:0] r_pix;
    logic [WC_W-1:0]   r_wcnt;
    logic              r_done;
    logic              r_rd_valid;

    logic w_idle;
    logic w_rd_ready;
    logic w_rd_acc;
    logic w_wt_last;
    logic w_last_pix;
    logic w_drop;

    // IDLE and DONE both accept start and readout requests. A copy outranks a read.
    assign w_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_rd_ready = w_idle && !start && !rst;
    assign w_rd_acc   = w_rd_ready && bus.rd_req;
    assign w_wt_last  = (r_state == S_WT) && (r_wcnt == WC_LAST);
    assign w_last_pix = (r_k == LAST_K);

`ifdef WARP_BOUNDS_CHECK_EN
    logic [19:0] r_drop;

    assign w_drop = (r_state == S_WR) && (r_woff >= NPIX_A);

    // Count suppressed out-of-frame writes. The count saturates and restarts with each copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 20'd0;
        end else if (w_idle && start) begin
            r_drop <= 20'd0;
        end else if (w_drop && (r_drop != 20'hFFFFF)) begin
            r_drop <= r_drop + 20'd1;
        end else begin
            r_drop <= r_drop;
        end
    end

    assign drop_count = r_drop;
`else
    assign w_drop     = 1'b0;
    assign drop_count = 20'd0;
`endif

    // State register. Reset aborts a copy immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic for the per-pixel read / wait / write sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = S_RD;
                end else begin
                    w_next = r_state;
                end
            end
            S_RD: w_next = S_WT;
            S_WT: begin
                if (w_wt_last) begin
                    w_next = S_WR;
                end else begin
                    w_next = S_WT;
                end
            end
            S_WR: begin
                if (w_last_pix) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Scan counters, wait counter, captured pixel/offset, done pulse and readout valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= {ADDR_W{1'b0}};
            r_woff     <= {ADDR_W{1'b0}};
            r_row      <= 10'd0;
            r_col      <= 10'd0;
            r_pix      <= {DATA_W{1'b0}};
            r_wcnt     <= {WC_W{1'b0}};
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_done     <= (r_state == S_WR) && w_last_pix;
            r_rd_valid <= w_rd_acc;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_k   <= {ADDR_W{1'b0}};
                        r_row <= 10'd0;
                        r_col <= 10'd0;
                    end
                end
                S_RD: r_wcnt <= {WC_W{1'b0}};
                S_WT: begin
                    if (w_wt_last) begin
                        r_pix  <= bus.ram_q;
                        r_woff <= warp_out;
                    end else begin
                        r_wcnt <= r_wcnt + WC_W'(1);
                    end
                end
                S_WR: begin
                    r_k <= r_k + ADDR_W'(1);
                    if (r_col == LAST_COL) begin
                        r_col <= 10'd0;
                        r_row <= r_row + 10'd1;
                    end else begin
                        r_col <= r_col + 10'd1;
                    end
                end
                default: r_k <= r_k;
            endcase
        end
    end

    // RAM port mux. The copy drives it while busy. An accepted readout drives it otherwise.
    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = {ADDR_W{1'b0}};
        bus.ram_data = {DATA_W{1'b0}};
        case (r_state)
            S_RD, S_WT: bus.ram_addr = SRC_A + r_k;
            S_WR: begin
                bus.ram_we   = !w_drop && !rst;
                bus.ram_addr = DST_A + r_woff;
                bus.ram_data = r_pix;
            end
            S_IDLE, S_DONE: begin
                if (w_rd_acc) begin
                    bus.ram_addr = DST_A + bus.rd_addr;
                end else begin
                    bus.ram_addr = {ADDR_W{1'b0}};
                end
            end
            default: bus.ram_addr = {ADDR_W{1'b0}};
        endcase
    end

    assign busy         = (r_state == S_RD) || (r_state == S_WT) || (r_state == S_WR);
    assign done         = r_done;
    assign warp_i       = r_row;
    assign warp_j       = r_col;
    assign bus.rd_ready = w_rd_ready;
    // Reset also cancels a result from a read accepted just before it
    assign bus.rd_valid = r_rd_valid && !rst;
    assign bus.rd_data  = (r_rd_valid && !rst) ? bus.ram_q : {DATA_W{1'b0}};
endmodule

// File: tb/tb_warp_sequencer.sv
// tb_warp_sequencer: directed checks of warp_sequencer on a reduced 4x3 frame.
// A behavioural RAM and warp model are included.
module tb_warp_sequencer;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int N   = W * H;
    localparam int DST = 400000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [9:0]  warp_i;
    logic [9:0]  warp_j;
    logic [20:0] warp_out;
    logic [19:0] drop_count;
    logic        oob_mode;
    int          w_k;
    logic [7:0]  mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    warp_sequencer_if #(.ADDR_W(21), .DATA_W(8)) bus ();

    warp_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .warp_i     (warp_i),
        .warp_j     (warp_j),
        .warp_out   (warp_out),
        .bus        (bus),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int k);
        return 8'(k * 37 + 5);
    endfunction

    // Warp model: identity mapping, or an out-of-frame offset for pixels 2..N-1
    always_comb begin
        w_k = int'(warp_i) * W + int'(warp_j);
        if (oob_mode && (w_k >= 2)) warp_out = 21'(N);
        else                        warp_out = 21'(w_k);
    end

    // RAM model: the source frame is a fixed pattern, and the destination window is stored
    always @(posedge clk) begin
        if (bus.ram_we && (int'(bus.ram_addr) >= DST) && (int'(bus.ram_addr) < DST + 64))
            mem[int'(bus.ram_addr) - DST] <= bus.ram_data;
        if (int'(bus.ram_addr) < N)
            bus.ram_q <= pat(int'(bus.ram_addr));
        else if ((int'(bus.ram_addr) >= DST) && (int'(bus.ram_addr) < DST + 64))
            bus.ram_q <= mem[int'(bus.ram_addr) - DST];
        else
            bus.ram_q <= 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full copy. Start is sampled at edge 0, and cycle c runs between edges c-1 and c.
    task automatic run_copy(input int extra_start_cyc, input bit with_rd, input int exp_wr,
                            input string nm);
        int wr_cnt;
        int done_cnt;
        int done_cyc;
        int bad_busy;
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; bad_busy = 0;
        @(posedge clk); #1;
        start = 1'b1; bus.rd_req = with_rd; bus.rd_addr = 21'd5;
        @(negedge clk);
        if (with_rd) check({nm, "_rdy_vs_start"}, 32'(bus.rd_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; bus.rd_req = 1'b0;
        for (int c = 1; c <= 3 * N + 4; c++) begin
            start = (c == extra_start_cyc);
            @(negedge clk);
            if (bus.ram_we) wr_cnt++;
            if (done) begin done_cnt++; done_cyc = c; end
            if (busy != (c <= 3 * N)) bad_busy++;
            if (c == 1) begin
                check({nm, "_rd_addr_p0"}, 32'(bus.ram_addr), 32'd0);
                check({nm, "_drop_clr"}, 32'(drop_count), 32'd0);
                if (with_rd) check({nm, "_no_rd_valid"}, 32'(bus.rd_valid), 32'd0);
            end
            if (c == 3) begin
                check({nm, "_wr_addr_p0"}, 32'(bus.ram_addr), 32'(DST));
                check({nm, "_wr_data_p0"}, 32'(bus.ram_data), 32'(pat(0)));
            end
            if (c == 1 + 3 * W) begin
                check({nm, "_row_wrap_i"}, 32'(warp_i), 32'd1);
                check({nm, "_row_wrap_j"}, 32'(warp_j), 32'd0);
            end
            if (c == 1 + 3 * (N - 1)) begin
                check({nm, "_last_i"}, 32'(warp_i), 32'(H - 1));
                check({nm, "_last_j"}, 32'(warp_j), 32'(W - 1));
                check({nm, "_last_src"}, 32'(bus.ram_addr), 32'(N - 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({nm, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
        check({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({nm, "_done_cyc"}, 32'(done_cyc), 32'(3 * N + 1));
        check({nm, "_busy_window"}, 32'(bad_busy), 32'd0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; oob_mode = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = 21'd0;

        // Reset, with start held during reset: reset dominates
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(bus.ram_we), 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_data", 32'(bus.ram_data), 32'd0);
        check("rst_wi", 32'(warp_i), 32'd0);
        check("rst_wj", 32'(warp_j), 32'd0);
        check("rst_rdv", 32'(bus.rd_valid), 32'd0);
        check("rst_rdd", 32'(bus.rd_data), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_idle_rdy", 32'(bus.rd_ready), 32'd1);

        // Identity copy
        run_copy(0, 1'b0, N, "id");
        for (int k = 0; k < N; k++) check($sformatf("id_mem%0d", k), 32'(mem[k]), 32'(pat(k)));

        // Readout from DONE, including back-to-back accepts
        bus.rd_req = 1'b1; bus.rd_addr = 21'd5;
        @(negedge clk);
        check("ro_ready", 32'(bus.rd_ready), 32'd1);
        check("ro_addr", 32'(bus.ram_addr), 32'(DST + 5));
        check("ro_we", 32'(bus.ram_we), 32'd0);
        @(posedge clk); #1 bus.rd_addr = 21'd2;
        @(negedge clk);
        check("ro_valid1", 32'(bus.rd_valid), 32'd1);
        check("ro_data1", 32'(bus.rd_data), 32'(pat(5)));
        @(posedge clk); #1 bus.rd_req = 1'b0;
        @(negedge clk);
        check("ro_valid2", 32'(bus.rd_valid), 32'd1);
        check("ro_data2", 32'(bus.rd_data), 32'(pat(2)));
        @(posedge clk); #1;
        @(negedge clk);
        check("ro_valid_off", 32'(bus.rd_valid), 32'd0);

        // A read accepted just before reset gives no result
        bus.rd_req = 1'b1; bus.rd_addr = 21'd3;
        @(posedge clk); #1;
        bus.rd_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_rdv_supp", 32'(bus.rd_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Start together with a read, plus start in mid-copy that must be ignored
        run_copy(5, 1'b1, N, "ign");

        // Reset in the WR cycle of pixel 3 (cycle 12)
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c < 12; c++) begin
            @(posedge clk);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_we", 32'(bus.ram_we), 32'd0);
        check("abort_busy_pre", 32'(busy), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_idle", 32'(bus.rd_ready), 32'd1);
        bad = 0;
        for (int c = 0; c < 3 * N + 4; c++) begin
            @(negedge clk);
            if (bus.ram_we || done || busy) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);

        // Out-of-frame warp for pixels 2..N-1 (10 pixels)
        oob_mode = 1'b1;
`ifdef WARP_BOUNDS_CHECK_EN
        run_copy(0, 1'b0, 2, "oob");
        check("oob_drop", 32'(drop_count), 32'd10);
`else
        run_copy(0, 1'b0, N, "oob");
        check("oob_drop", 32'(drop_count), 32'd0);
`endif
        oob_mode = 1'b0;
        run_copy(0, 1'b0, N, "clr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
